// File: rtl/dmem_responder.sv
// Single-port-style data memory for the MEM stage: one-cycle registered read,
// write-first bypass, init-port priority and an optional self-clear after reset.
module dmem_responder #(
  parameter int DMEM_ADDR_WIDTH = 12,
  parameter int DMEM_WORD_WIDTH = 16,
  parameter int CLEAR_ON_RESET  = 1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [DMEM_ADDR_WIDTH-1:0] in_mem_rd_addr,
  input  logic [DMEM_ADDR_WIDTH-1:0] in_mem_wr_addr,
  input  logic [DMEM_WORD_WIDTH-1:0] in_mem_wr_word,
  input  logic                       in_mem_write_en,
  input  logic                       in_init_en,
  input  logic [DMEM_ADDR_WIDTH-1:0] in_init_addr,
  input  logic [DMEM_WORD_WIDTH-1:0] in_init_word,
  output logic [DMEM_WORD_WIDTH-1:0] out_mem_rd_word,
  output logic                       out_busy
);

  localparam int DEPTH = 1 << DMEM_ADDR_WIDTH;
  localparam logic [DMEM_ADDR_WIDTH-1:0] CNT_LAST = {DMEM_ADDR_WIDTH{1'b1}};
  localparam logic [DMEM_ADDR_WIDTH-1:0] CNT_ONE  = DMEM_ADDR_WIDTH'(1);

  typedef enum logic [0:0] {
    S_CLEAR = 1'b0,
    S_IDLE  = 1'b1
  } state_t;

  localparam state_t RST_STATE = (CLEAR_ON_RESET != 0) ? S_CLEAR : S_IDLE;

  logic [DMEM_WORD_WIDTH-1:0] mem_q [DEPTH];

  state_t                     state_q,  state_d;
  logic [DMEM_ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
  logic [DMEM_WORD_WIDTH-1:0] rd_word_q, rd_word_d;

  logic                       wr_en_s;
  logic [DMEM_ADDR_WIDTH-1:0] wr_addr_s;
  logic [DMEM_WORD_WIDTH-1:0] wr_word_s;

  // Next state, effective write port and read-data selection.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    rd_word_d = {DMEM_WORD_WIDTH{1'b0}};
    wr_en_s   = 1'b0;
    wr_addr_s = {DMEM_ADDR_WIDTH{1'b0}};
    wr_word_s = {DMEM_WORD_WIDTH{1'b0}};
    case (state_q)
      S_CLEAR: begin
        wr_en_s   = 1'b1;
        wr_addr_s = clr_cnt_q;
        if (clr_cnt_q == CNT_LAST) begin
          state_d   = S_IDLE;
          clr_cnt_d = {DMEM_ADDR_WIDTH{1'b0}};
        end else begin
          clr_cnt_d = clr_cnt_q + CNT_ONE;
        end
      end
      S_IDLE: begin
        // The init port wins a collision; the pipeline store is silently dropped.
        if (in_init_en) begin
          wr_en_s   = 1'b1;
          wr_addr_s = in_init_addr;
          wr_word_s = in_init_word;
        end else if (in_mem_write_en) begin
          wr_en_s   = 1'b1;
          wr_addr_s = in_mem_wr_addr;
          wr_word_s = in_mem_wr_word;
        end else begin
          wr_en_s   = 1'b0;
        end
        if (wr_en_s && (wr_addr_s == in_mem_rd_addr)) begin
          rd_word_d = wr_word_s;
        end else begin
          rd_word_d = mem_q[in_mem_rd_addr];
        end
      end
      default: begin
        state_d   = RST_STATE;
        clr_cnt_d = {DMEM_ADDR_WIDTH{1'b0}};
      end
    endcase
  end

  // Control and read-data registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= RST_STATE;
      clr_cnt_q <= {DMEM_ADDR_WIDTH{1'b0}};
      rd_word_q <= {DMEM_WORD_WIDTH{1'b0}};
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      rd_word_q <= rd_word_d;
    end
  end

  // Storage array: never touched by reset itself; reset also blocks any write.
  always_ff @(posedge clock) begin
    if (!reset && wr_en_s) begin
      mem_q[wr_addr_s] <= wr_word_s;
    end
  end

  assign out_mem_rd_word = rd_word_q;
  assign out_busy        = (state_q == S_CLEAR);

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: one instance clears on reset, one does not.
module tb_dmem_responder;

  localparam int AW = 4;
  localparam int WW = 16;

  typedef struct {
    int          which;
    logic [15:0] word;
    logic        busy;
    string       name;
  } exp_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic          reset_a = 1'b1;
  logic          reset_b = 1'b1;
  logic [AW-1:0] rd_addr = '0;
  logic [AW-1:0] wr_addr = '0;
  logic [WW-1:0] wr_word = '0;
  logic          wr_en   = 1'b0;
  logic          init_en = 1'b0;
  logic [AW-1:0] init_addr = '0;
  logic [WW-1:0] init_word = '0;

  logic [WW-1:0] a_rd, b_rd;
  logic          a_busy, b_busy;

  dmem_responder #(.DMEM_ADDR_WIDTH(AW), .DMEM_WORD_WIDTH(WW), .CLEAR_ON_RESET(1)) dut_a (
    .clock(clock), .reset(reset_a),
    .in_mem_rd_addr(rd_addr), .in_mem_wr_addr(wr_addr), .in_mem_wr_word(wr_word),
    .in_mem_write_en(wr_en), .in_init_en(init_en), .in_init_addr(init_addr),
    .in_init_word(init_word), .out_mem_rd_word(a_rd), .out_busy(a_busy)
  );

  dmem_responder #(.DMEM_ADDR_WIDTH(AW), .DMEM_WORD_WIDTH(WW), .CLEAR_ON_RESET(0)) dut_b (
    .clock(clock), .reset(reset_b),
    .in_mem_rd_addr(rd_addr), .in_mem_wr_addr(wr_addr), .in_mem_wr_word(wr_word),
    .in_mem_write_en(wr_en), .in_init_en(init_en), .in_init_addr(init_addr),
    .in_init_word(init_word), .out_mem_rd_word(b_rd), .out_busy(b_busy)
  );

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  logic chk_req = 1'b0;
  logic chk_dly = 1'b0;

  // An expectation queued in cycle N is due after the following rising edge.
  always @(posedge clock) chk_dly <= chk_req;

  always @(negedge clock) begin
    exp_t        e;
    logic [15:0] aw;
    logic        ab;
    if (chk_dly) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty: output presented with no expectation queued");
      end else begin
        e  = q.pop_front();
        aw = (e.which == 0) ? a_rd : b_rd;
        ab = (e.which == 0) ? a_busy : b_busy;
        if (aw !== e.word || ab !== e.busy) begin
          errors++;
          $display("FAIL %s: got rd_word=%h busy=%b, expected rd_word=%h busy=%b",
                   e.name, aw, ab, e.word, e.busy);
        end
      end
    end
  end

  task automatic drv(input logic [AW-1:0] ra, input logic ie, input logic [AW-1:0] ia,
                     input logic [WW-1:0] iw, input logic me, input logic [AW-1:0] ma,
                     input logic [WW-1:0] mw);
    rd_addr = ra; init_en = ie; init_addr = ia; init_word = iw;
    wr_en = me; wr_addr = ma; wr_word = mw;
  endtask

  task automatic cyc(input bit chk, input int which, input logic [15:0] w,
                     input logic b, input string nm);
    exp_t e;
    if (chk) begin
      e.which = which; e.word = w; e.busy = b; e.name = nm;
      q.push_back(e);
    end
    chk_req = chk;
    @(negedge clock);
  endtask

  initial begin
    @(negedge clock);
    // Reset then a full 16-cycle clear on instance A.
    drv(4'h0, 1'b0, 4'h0, 16'h0000, 1'b0, 4'h0, 16'h0000);
    reset_a = 1'b1; reset_b = 1'b1;
    cyc(1, 0, 16'h0000, 1'b1, "reset_state");
    reset_a = 1'b0; reset_b = 1'b0;
    for (int i = 1; i < 16; i++) cyc(1, 0, 16'h0000, 1'b1, "clear_busy");
    cyc(1, 0, 16'h0000, 1'b0, "clear_done");
    for (int i = 0; i < 16; i++) begin
      drv(AW'(i), 1'b0, 4'h0, 16'h0000, 1'b0, 4'h0, 16'h0000);
      cyc(1, 0, 16'h0000, 1'b0, "cleared_word");
    end

    // Pipeline store then read one cycle later.
    drv(4'h0, 1'b0, 4'h0, 16'h0000, 1'b1, 4'h5, 16'hBEEF);
    cyc(1, 0, 16'h0000, 1'b0, "rd0_during_store");
    drv(4'h5, 1'b0, 4'h0, 16'h0000, 1'b0, 4'h0, 16'h0000);
    cyc(1, 0, 16'hBEEF, 1'b0, "store_readback");

    // Write-first bypass.
    drv(4'hA, 1'b0, 4'h0, 16'h0000, 1'b1, 4'hA, 16'h1234);
    cyc(1, 0, 16'h1234, 1'b0, "bypass_pipe");
    drv(4'hA, 1'b0, 4'h0, 16'h0000, 1'b0, 4'h0, 16'h0000);
    cyc(1, 0, 16'h1234, 1'b0, "bypass_stored");

    // Init port beats the pipeline port.
    drv(4'h0, 1'b1, 4'h3, 16'hAAAA, 1'b1, 4'h3, 16'h5555);
    cyc(1, 0, 16'h0000, 1'b0, "rd0_during_init");
    drv(4'h6, 1'b1, 4'h4, 16'h4444, 1'b1, 4'h6, 16'h7777);
    cyc(1, 0, 16'h0000, 1'b0, "pipe_not_bypassed");
    drv(4'h3, 1'b0, 4'h0, 16'h0000, 1'b0, 4'h0, 16'h0000);
    cyc(1, 0, 16'hAAAA, 1'b0, "init_wins");
    drv(4'h6, 1'b0, 4'h0, 16'h0000, 1'b0, 4'h0, 16'h0000);
    cyc(1, 0, 16'h0000, 1'b0, "pipe_dropped");
    drv(4'h4, 1'b0, 4'h0, 16'h0000, 1'b0, 4'h0, 16'h0000);
    cyc(1, 0, 16'h4444, 1'b0, "init_other_addr");
    drv(4'hF, 1'b1, 4'hF, 16'h9999, 1'b0, 4'h0, 16'h0000);
    cyc(1, 0, 16'h9999, 1'b0, "bypass_init_top");

    // Preload, then reset mid-clear with stores attempted throughout.
    drv(4'h2, 1'b1, 4'h2, 16'hCAFE, 1'b0, 4'h0, 16'h0000);
    cyc(1, 0, 16'hCAFE, 1'b0, "preload_bypass");
    drv(4'h2, 1'b0, 4'h0, 16'h0000, 1'b0, 4'h0, 16'h0000);
    cyc(1, 0, 16'hCAFE, 1'b0, "preload_read");
    reset_a = 1'b1;
    cyc(1, 0, 16'h0000, 1'b1, "reset2");
    reset_a = 1'b0;
    drv(4'h2, 1'b1, 4'h1, 16'h1111, 1'b1, 4'h1, 16'h1111);
    for (int i = 0; i < 5; i++) cyc(1, 0, 16'h0000, 1'b1, "clear_rd_zero");
    reset_a = 1'b1;
    cyc(1, 0, 16'h0000, 1'b1, "reset_mid_clear");
    reset_a = 1'b0;
    for (int i = 1; i < 16; i++) cyc(1, 0, 16'h0000, 1'b1, "restart_busy");
    cyc(1, 0, 16'h0000, 1'b0, "restart_done");
    drv(4'h1, 1'b0, 4'h0, 16'h0000, 1'b0, 4'h0, 16'h0000);
    cyc(1, 0, 16'h0000, 1'b0, "clear_ignored_store");
    drv(4'h2, 1'b0, 4'h0, 16'h0000, 1'b0, 4'h0, 16'h0000);
    cyc(1, 0, 16'h0000, 1'b0, "preload_cleared");

    // Instance B keeps its contents across reset.
    drv(4'h0, 1'b1, 4'h7, 16'h0F0F, 1'b0, 4'h0, 16'h0000);
    cyc(0, 1, 16'h0000, 1'b0, "");
    drv(4'h7, 1'b0, 4'h0, 16'h0000, 1'b0, 4'h0, 16'h0000);
    cyc(1, 1, 16'h0F0F, 1'b0, "b_preload");
    reset_b = 1'b1;
    cyc(1, 1, 16'h0000, 1'b0, "b_reset");
    reset_b = 1'b0;
    cyc(1, 1, 16'h0F0F, 1'b0, "b_retained");
    cyc(1, 1, 16'h0F0F, 1'b0, "b_idle_busy_low");

    drv(4'h0, 1'b0, 4'h0, 16'h0000, 1'b0, 4'h0, 16'h0000);
    cyc(0, 0, 16'h0000, 1'b0, "");
    cyc(0, 0, 16'h0000, 1'b0, "");
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d expectations left, expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
- REQ-001 SHALL have parameter DMEM_ADDR_WIDTH, default 12, word address width; depth = 2^DMEM_ADDR_WIDTH.
- REQ-002 SHALL have parameter DMEM_WORD_WIDTH, default 16, data word width.
- REQ-003 SHALL have parameter CLEAR_ON_RESET, default 1; 1 = zero whole array after reset, 0 = array contents untouched by reset.
- REQ-004 SHALL have one clock; reset is synchronous and active-high.
- REQ-005 clock  input  1  sole clock; all state updates on rising edge.
- REQ-006 reset  input  1  synchronous active-high reset.
- REQ-007 in_mem_rd_addr  input  DMEM_ADDR_WIDTH  read address from MEM stage.
- REQ-008 in_mem_wr_addr  input  DMEM_ADDR_WIDTH  write address from MEM stage.
- REQ-009 in_mem_wr_word  input  DMEM_WORD_WIDTH  write data from MEM stage.
- REQ-010 in_mem_write_en  input  1  pipeline store strobe.
- REQ-011 in_init_en  input  1  preload/debug write strobe.
- REQ-012 in_init_addr  input  DMEM_ADDR_WIDTH  preload address.
- REQ-013 in_init_word  input  DMEM_WORD_WIDTH  preload data.
- REQ-014 out_mem_rd_word  output  DMEM_WORD_WIDTH  registered read data to MEM stage.
- REQ-015 out_busy  output  1  high while clear sequence runs.

Function
- REQ-016 SHALL implement a two-state FSM: CLEAR, IDLE; out_busy = (state == CLEAR), combinational from state.
- REQ-017 SHALL hold a DMEM_ADDR_WIDTH-bit clear counter and a DMEM_WORD_WIDTH-bit read-data register driving out_mem_rd_word directly.
- REQ-018 In CLEAR, each cycle SHALL write 0 to array[clear counter] and increment counter; when counter == 2^DMEM_ADDR_WIDTH-1, write 0 and go IDLE; clear takes exactly 2^DMEM_ADDR_WIDTH cycles.
- REQ-019 In CLEAR, pipeline and init writes SHALL be ignored and read-data register SHALL load 0 every cycle.
- REQ-020 In IDLE, effective write: if in_init_en, array[in_init_addr] <= in_init_word; else if in_mem_write_en, array[in_mem_wr_addr] <= in_mem_wr_word; else none.
- REQ-021 Both strobes high in same IDLE cycle: only init write SHALL occur; pipeline write dropped, no error flag.
- REQ-022 In IDLE, read-data register SHALL load array[in_mem_rd_addr] each edge; read latency one cycle (address at edge N, data valid after edge N until edge N+1).
- REQ-023 Read and effective write to same address in same IDLE cycle: read-data register SHALL load the new write data (write-first bypass).
- REQ-024 Reads SHALL be unconditional (no read enable); address compare uses full DMEM_ADDR_WIDTH bits, no wrap beyond width.
- REQ-025 Clear counter SHALL wrap only via the terminal transition of REQ-018; counter value in IDLE is don't-care.

Reset
- REQ-026 On reset high at an edge: state <= CLEAR if CLEAR_ON_RESET=1 else IDLE; clear counter <= 0; read-data register <= 0.
- REQ-027 After reset: out_mem_rd_word = 0; out_busy = 1 if CLEAR_ON_RESET=1, else 0.
- REQ-028 Reset during CLEAR SHALL restart clear at address 0; reset SHALL take priority over all writes in that cycle.
- REQ-029 With CLEAR_ON_RESET=0, reset SHALL not modify array contents.

Verification
- REQ-030 DMEM_ADDR_WIDTH=4, CLEAR_ON_RESET=1: one reset cycle -> out_busy high exactly 16 cycles, then 0; reads of addr 0..15 all return 0x0000.
- REQ-031 IDLE: write 0xBEEF to 0x005 via in_mem_write_en, next cycle read 0x005 -> out_mem_rd_word = 0xBEEF one cycle after read address presented.
- REQ-032 Same cycle: write 0x1234 to 0x00A and read 0x00A (old 0x0000) -> out_mem_rd_word = 0x1234 after that edge.
- REQ-033 Same cycle: in_init_en to 0x003 = 0xAAAA, in_mem_write_en to 0x003 = 0x5555 -> later read 0x003 = 0xAAAA; also init to 0x004 with pipe write to 0x006 = 0x7777 -> 0x006 unchanged.
- REQ-034 Preload 0xCAFE at 0x002, assert reset at clear cycle 5, write 0x1111 to 0x001 during CLEAR -> clear restarts (16 further busy cycles), reads of 0x001/0x002 return 0x0000, out_mem_rd_word = 0 during CLEAR.
- REQ-035 CLEAR_ON_RESET=0: preload 0x0F0F at 0x007, reset -> out_busy stays 0, out_mem_rd_word = 0 after reset, then read 0x007 = 0x0F0F.
